// File: rtl/sd_card_write_ctrl.sv
// SD card single-block write (CMD24) sequencer: token, 512 data bytes, dummy CRC, response and busy wait.
// Optional macro SD_WRITE_TIMEOUT_EN bounds the response/busy waits with a 16-bit cycle counter.
module sd_card_write_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start_write,
    input  logic [31:0] i_addr,
    output logic [31:0] o_addr,
    output logic        o_wr_nrd,
    input  logic [7:0]  i_data,
    output logic        o_send_cmd,
    output logic [2:0]  o_cmd_select,
    output logic [31:0] o_cmd_arg,
    input  logic        i_confirm_pin,
    input  logic [7:0]  i_response_status,
    input  logic        i_sd_DO,
    input  logic [7:0]  i_accept_register,
    output logic        o_cmd_line_select,
    output logic        o_write_data_output,
    output logic        o_write_done,
    output logic [7:0]  o_status
);

    typedef enum logic [3:0] {
        IDLE, CMD, WAIT_R1, TOKEN, DATA, CRC, WAIT_RESP, BUSY, DONE
    } state_t;

    localparam logic [2:0] CMD24      = 3'd4;
    localparam logic [4:0] RESP_OK    = 5'b00101;
    localparam logic [4:0] RESP_CRC   = 5'b01011;
    localparam logic [4:0] RESP_WRERR = 5'b01101;

    state_t      state, state_nxt;
    logic [31:0] blk_addr;
    logic [8:0]  buf_addr;
    logic [8:0]  byte_cnt;
    logic [2:0]  bit_cnt;
    logic [3:0]  crc_cnt;
    logic [7:0]  shreg;
    logic [7:0]  status;

    logic unused_accept;
    assign unused_accept = &{1'b0, i_accept_register[7:5]};

`ifdef SD_WRITE_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        waiting;
    logic        timeout;
    assign waiting = (state == WAIT_R1) || (state == WAIT_RESP) || (state == BUSY);
    assign timeout = waiting && (to_cnt == 16'hFFFE);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (i_start_write) state_nxt = CMD;
            CMD:       state_nxt = WAIT_R1;
            WAIT_R1:   if (i_confirm_pin)
                           state_nxt = (i_response_status == 8'h00) ? TOKEN : DONE;
            TOKEN:     if (bit_cnt == 3'd7) state_nxt = DATA;
            DATA:      if (bit_cnt == 3'd7 && byte_cnt == 9'd511) state_nxt = CRC;
            CRC:       if (crc_cnt == 4'd15) state_nxt = WAIT_RESP;
            WAIT_RESP: begin
                if (i_accept_register[4:0] == RESP_OK)
                    state_nxt = BUSY;
                else if (i_accept_register[4:0] == RESP_CRC ||
                         i_accept_register[4:0] == RESP_WRERR)
                    state_nxt = DONE;
            end
            BUSY:      if (i_sd_DO) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
`ifdef SD_WRITE_TIMEOUT_EN
        if (timeout) state_nxt = DONE;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            blk_addr <= 32'd0;
            buf_addr <= 9'd0;
            byte_cnt <= 9'd0;
            bit_cnt  <= 3'd0;
            crc_cnt  <= 4'd0;
            shreg    <= 8'hFF;
            status   <= 8'h00;
`ifdef SD_WRITE_TIMEOUT_EN
            to_cnt   <= 16'd0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (i_start_write) begin
                    blk_addr <= i_addr;
                    buf_addr <= 9'd0;
                    status   <= 8'h01;
`ifdef SD_WRITE_TIMEOUT_EN
                    to_cnt   <= 16'd0;
`endif
                end
                WAIT_R1: if (i_confirm_pin) begin
                    if (i_response_status == 8'h00) begin
                        shreg   <= 8'hFE;
                        bit_cnt <= 3'd0;
                    end else begin
                        status  <= {1'b1, i_response_status[6:0]};
                    end
                end
                // Buffer address 0 was presented through TOKEN, so byte 0 is ready at its last bit
                TOKEN: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        shreg    <= i_data;
                        buf_addr <= buf_addr + 9'd1;
                        byte_cnt <= 9'd0;
                    end else begin
                        shreg    <= {shreg[6:0], 1'b1};
                    end
                end
                DATA: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_cnt <= byte_cnt + 9'd1;
                        crc_cnt  <= 4'd0;
                        if (byte_cnt != 9'd511) begin
                            shreg    <= i_data;
                            buf_addr <= buf_addr + 9'd1;
                        end
                    end else begin
                        shreg <= {shreg[6:0], 1'b1};
                    end
                end
                CRC: crc_cnt <= crc_cnt + 4'd1;
                WAIT_RESP: begin
                    if (i_accept_register[4:0] == RESP_CRC)
                        status <= 8'h82;
                    else if (i_accept_register[4:0] == RESP_WRERR)
                        status <= 8'h83;
                end
                BUSY: if (i_sd_DO) status <= 8'h00;
                default: ;
            endcase
`ifdef SD_WRITE_TIMEOUT_EN
            if (waiting) begin
                to_cnt <= to_cnt + 16'd1;
                if (timeout) status <= 8'h84;
            end
`endif
        end
    end

    assign o_addr              = {23'd0, buf_addr};
    assign o_wr_nrd            = 1'b0;
    assign o_send_cmd          = (state == CMD);
    assign o_cmd_select        = (state == CMD) ? CMD24 : 3'd0;
    assign o_cmd_arg           = blk_addr;
    assign o_cmd_line_select   = (state == TOKEN) || (state == DATA) || (state == CRC) ||
                                 (state == WAIT_RESP) || (state == BUSY);
    assign o_write_data_output = (state == TOKEN || state == DATA) ? shreg[7] : 1'b1;
    assign o_write_done        = (state == DONE);
    assign o_status            = status;

endmodule

// File: tb/tb_sd_card_write_ctrl.sv
// Directed bench for sd_card_write_ctrl: models the source buffer, command engine and card response.
module tb_sd_card_write_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start_write = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] o_addr;
    logic        o_wr_nrd;
    logic [7:0]  i_data = 8'd0;
    logic        o_send_cmd;
    logic [2:0]  o_cmd_select;
    logic [31:0] o_cmd_arg;
    logic        i_confirm_pin = 1'b0;
    logic [7:0]  i_response_status = 8'd0;
    logic        i_sd_DO = 1'b1;
    logic [7:0]  i_accept_register = 8'hFF;
    logic        o_cmd_line_select;
    logic        o_write_data_output;
    logic        o_write_done;
    logic [7:0]  o_status;

    int tests = 0;
    int fails = 0;
    int cmd_cnt = 0;
    int done_cnt = 0;
    logic [2:0]  last_sel;
    logic [31:0] last_arg;
    logic        dbits[$];

    sd_card_write_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start_write(i_start_write), .i_addr(i_addr),
        .o_addr(o_addr), .o_wr_nrd(o_wr_nrd), .i_data(i_data),
        .o_send_cmd(o_send_cmd), .o_cmd_select(o_cmd_select), .o_cmd_arg(o_cmd_arg),
        .i_confirm_pin(i_confirm_pin), .i_response_status(i_response_status),
        .i_sd_DO(i_sd_DO), .i_accept_register(i_accept_register),
        .o_cmd_line_select(o_cmd_line_select), .o_write_data_output(o_write_data_output),
        .o_write_done(o_write_done), .o_status(o_status)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] buf_byte(input int n);
        int v;
        v = n * 37 + (n >> 8) * 91 + 11;
        return v[7:0];
    endfunction

    // Source buffer with one-cycle synchronous read
    always @(posedge i_clk) i_data <= buf_byte(int'(o_addr[8:0]));

    always @(negedge i_clk) begin
        if (o_send_cmd) begin
            cmd_cnt  = cmd_cnt + 1;
            last_sel = o_cmd_select;
            last_arg = o_cmd_arg;
        end
        if (o_write_done) done_cnt = done_cnt + 1;
        if (o_cmd_line_select) dbits.push_back(o_write_data_output);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_stream(input string tag);
        int errs;
        int ones;
        logic [7:0] tok;
        logic [7:0] e;
        chk({tag, "_bitcount"}, 32'(dbits.size() >= 4120), 32'd1);
        if (dbits.size() >= 4120) begin
            tok = 8'd0;
            for (int b = 0; b < 8; b++) tok = {tok[6:0], dbits[b]};
            chk({tag, "_token"}, 32'(tok), 32'hFE);
            errs = 0;
            for (int n = 0; n < 512; n++) begin
                e = buf_byte(n);
                for (int b = 0; b < 8; b++)
                    if (dbits[8 + 8 * n + b] !== e[7 - b]) errs++;
            end
            chk({tag, "_data_bit_errors"}, 32'(errs), 32'd0);
            ones = 0;
            for (int i = 4104; i < 4120; i++) if (dbits[i] === 1'b1) ones++;
            chk({tag, "_crc_ones"}, 32'(ones), 32'd16);
        end
    endtask

    task automatic pulse_start(input logic [31:0] addr);
        @(posedge i_clk); #1;
        i_addr = addr;
        i_start_write = 1'b1;
        @(posedge i_clk); #1;
        i_start_write = 1'b0;
    endtask

    // Start, answer CMD24, wait for the serial block; returns with the DUT in WAIT_RESP
    task automatic start_and_r1(input string tag, input logic [31:0] addr, input logic [7:0] r1);
        int c0;
        c0 = cmd_cnt;
        dbits.delete();
        pulse_start(addr);
        for (int k = 0; k < 20 && cmd_cnt == c0; k++) @(posedge i_clk);
        #1;
        chk({tag, "_cmd_count"}, 32'(cmd_cnt - c0), 32'd1);
        chk({tag, "_cmd_select"}, 32'(last_sel), 32'd4);
        chk({tag, "_cmd_arg"}, last_arg, addr);
        repeat (2) @(posedge i_clk);
        #1;
        chk({tag, "_status_busy"}, 32'(o_status), 32'h01);
        i_response_status = r1;
        i_confirm_pin = 1'b1;
        @(posedge i_clk); #1;
        i_confirm_pin = 1'b0;
    endtask

    task automatic wait_stream(input logic restart);
        logic pulsed;
        pulsed = 1'b0;
        for (int k = 0; k < 6000 && dbits.size() < 4120; k++) begin
            @(negedge i_clk);
            if (restart && !pulsed && dbits.size() >= 2000) begin
                i_addr = 32'hDEAD;
                i_start_write = 1'b1;
                pulsed = 1'b1;
            end else begin
                i_start_write = 1'b0;
            end
        end
        i_start_write = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int bound);
        for (int k = 0; k < bound && done_cnt == d0; k++) @(posedge i_clk);
        repeat (5) @(posedge i_clk);
        #1;
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic full_write(input string tag, input logic [31:0] addr, input logic [4:0] resp,
                              input logic restart, input logic [7:0] exp_status);
        int d0;
        int c0;
        d0 = done_cnt;
        c0 = cmd_cnt;
        start_and_r1(tag, addr, 8'h00);
        wait_stream(restart);
        repeat (2) @(posedge i_clk);
        #1;
        i_sd_DO = 1'b0;
        i_accept_register = {3'b111, resp};
        if (resp == 5'b00101) begin
            repeat (3) @(posedge i_clk);
            #1;
            i_sd_DO = 1'b1;
        end
        wait_done(tag, d0, 100);
        chk({tag, "_status"}, 32'(o_status), 32'(exp_status));
        chk({tag, "_total_cmds"}, 32'(cmd_cnt - c0), 32'd1);
        chk({tag, "_addr_wrapped"}, o_addr, 32'd0);
        chk({tag, "_line_released"}, 32'(o_cmd_line_select), 32'd0);
        check_stream(tag);
        i_accept_register = 8'hFF;
        i_sd_DO = 1'b1;
    endtask

    initial begin
        int d0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_status", 32'(o_status), 32'h00);
        chk("rst_di", 32'(o_write_data_output), 32'd1);
        chk("rst_line_sel", 32'(o_cmd_line_select), 32'd0);
        chk("rst_send_cmd", 32'(o_send_cmd), 32'd0);
        chk("rst_done", 32'(o_write_done), 32'd0);
        chk("rst_cmd_arg", o_cmd_arg, 32'd0);
        chk("rst_wr_nrd", 32'(o_wr_nrd), 32'd0);
        i_rst = 1'b0;

        full_write("ok", 32'h10, 5'b00101, 1'b0, 8'h00);

        d0 = done_cnt;
        start_and_r1("r1err", 32'h20, 8'h04);
        wait_done("r1err", d0, 50);
        chk("r1err_status", 32'(o_status), 32'h84);
        chk("r1err_no_token", 32'(dbits.size()), 32'd0);

        full_write("crcerr", 32'h30, 5'b01011, 1'b0, 8'h82);
        full_write("wrerr", 32'h40, 5'b01101, 1'b0, 8'h83);
        full_write("restart", 32'h50, 5'b00101, 1'b1, 8'h00);

        d0 = done_cnt;
        start_and_r1("abort", 32'h60, 8'h00);
        for (int k = 0; k < 1000 && dbits.size() < 200; k++) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        chk("abort_status", 32'(o_status), 32'h00);
        chk("abort_addr", o_addr, 32'd0);
        chk("abort_send_cmd", 32'(o_send_cmd), 32'd0);
        chk("abort_cmd_select", 32'(o_cmd_select), 32'd0);
        chk("abort_cmd_arg", o_cmd_arg, 32'd0);
        chk("abort_line_sel", 32'(o_cmd_line_select), 32'd0);
        chk("abort_di", 32'(o_write_data_output), 32'd1);
        chk("abort_done", 32'(o_write_done), 32'd0);
        i_rst = 1'b0;
        repeat (30) @(posedge i_clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

`ifdef SD_WRITE_TIMEOUT_EN
        d0 = done_cnt;
        start_and_r1("timeout", 32'h70, 8'h00);
        wait_stream(1'b0);
        repeat (2) @(posedge i_clk);
        #1;
        i_sd_DO = 1'b0;
        i_accept_register = {3'b111, 5'b00101};
        wait_done("timeout", d0, 70000);
        chk("timeout_status", 32'(o_status), 32'h84);
        i_sd_DO = 1'b1;
        i_accept_register = 8'hFF;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
